// File: rtl/branch_pkg.sv
// Purpose: shared opcode constants, enums and branch-class decode for branch_ctrl.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
//
// Contents: LEGv8 branch opcode fields, condition-code enum, FSM state enum,
// branch-class enum, and decodeClass() which maps an instruction word to a class.
package branch_pkg;

   // Opcode fields: B/BL match on instr[31:26], the rest on instr[31:24].
   localparam logic [5:0] OP_B     = 6'b000101;
   localparam logic [5:0] OP_BL    = 6'b100101;
   localparam logic [7:0] OP_CBZ   = 8'b10110100;
   localparam logic [7:0] OP_CBNZ  = 8'b10110101;
   localparam logic [7:0] OP_BCOND = 8'b01010100;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } condT;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESOLVE = 2'd1,
      FLUSH   = 2'd2
   } stateT;

   typedef enum logic [2:0] {
      BR_NONE  = 3'd0,
      BR_B     = 3'd1,
      BR_BL    = 3'd2,
      BR_CBZ   = 3'd3,
      BR_CBNZ  = 3'd4,
      BR_BCOND = 3'd5
   } brClassT;

   // Anything that is not one of the five branch encodings decodes to BR_NONE.
   function automatic brClassT decodeClass(input logic [31:0] word);
      brClassT cls;
      cls = BR_NONE;
      if (word[31:26] == OP_B)
         cls = BR_B;
      else if (word[31:26] == OP_BL)
         cls = BR_BL;
      else if (word[31:24] == OP_CBZ)
         cls = BR_CBZ;
      else if (word[31:24] == OP_CBNZ)
         cls = BR_CBNZ;
      else if (word[31:24] == OP_BCOND)
         cls = BR_BCOND;
      return cls;
   endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Purpose: evaluate an ARM condition code against NZCV flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: cond[3:0] condition code; n, z, c, v flag bits; taken = condition holds.
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       c,
   input  logic       v,
   output logic       taken
);

   logic base;

   // Conditions come in complementary pairs: cond[3:1] selects the base
   // test and cond[0] inverts it, except for the always-true pair 111x.
   always_comb begin
      base = 1'b1;
      unique case (cond[3:1])
         3'd0:    base = z;                    // EQ / NE
         3'd1:    base = c;                    // HS / LO
         3'd2:    base = n;                    // MI / PL
         3'd3:    base = v;                    // VS / VC
         3'd4:    base = c & ~z;               // HI / LS
         3'd5:    base = (n == v);             // GE / LT
         3'd6:    base = ~z & (n == v);        // GT / LE
         default: base = 1'b1;                 // AL / NV
      endcase
   end

   assign taken = (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);

endmodule

// File: rtl/branch_ctrl.sv
// Purpose: decode LEGv8 branches, hold NZCV, resolve and drive the PC datapath controls.
// Latency: decode in cycle N, resolve (brTaken/stall/link) in N+1, flush in N+2 if taken.
// Backpressure: stall holds fetch for the single RESOLVE cycle; new instructions are ignored in RESOLVE and FLUSH.
//
// Ports: clk, reset (async, active-high); instr/instrValid fetched word;
// aluFlags/setFlags flag update from execute; regZero Rt==0 during RESOLVE;
// uncondBr, brTaken, condAddr19, brAddr26, link to the PC datapath;
// stall, flush to fetch; flags current NZCV register.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int INSTR_W = 32
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instrValid,
   input  logic [3:0]         aluFlags,
   input  logic               setFlags,
   input  logic               regZero,
   output logic               uncondBr,
   output logic               brTaken,
   output logic [18:0]        condAddr19,
   output logic [25:0]        brAddr26,
   output logic               link,
   output logic               stall,
   output logic               flush,
   output logic [3:0]         flags
);

   stateT       state;
   stateT       nextState;
   brClassT     decClass;
   brClassT     capClass;
   logic [3:0]  capCond;
   logic [18:0] capAddr19;
   logic [25:0] capAddr26;
   logic [3:0]  flagsReg;
   logic [3:0]  evalFlags;
   logic        capture;
   logic        condTaken;
   logic        resolveTaken;

   assign decClass = decodeClass(instr[31:0]);
   assign capture  = (state == IDLE) && instrValid && (decClass != BR_NONE);

   // ---------------- state and capture registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capClass  <= BR_NONE;
         capCond   <= 4'h0;
         capAddr19 <= '0;
         capAddr26 <= '0;
      end else if (capture) begin
         capClass  <= decClass;
         capCond   <= instr[3:0];
         capAddr19 <= instr[23:5];
         capAddr26 <= instr[25:0];
      end
   end

   // Flag register loads whenever a flag-setting op completes, in any state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flagsReg <= 4'h0;
      else if (setFlags)
         flagsReg <= aluFlags;
   end

   assign flags = flagsReg;

   // A flag-setting op completing in the same cycle as RESOLVE has not yet
   // reached flagsReg, so forward it straight into the condition check.
   assign evalFlags = setFlags ? aluFlags : flagsReg;

   cond_eval uCondEval (
      .cond  (capCond),
      .n     (evalFlags[3]),
      .z     (evalFlags[2]),
      .c     (evalFlags[1]),
      .v     (evalFlags[0]),
      .taken (condTaken)
   );

   always_comb begin
      resolveTaken = 1'b0;
      unique case (capClass)
         BR_B, BR_BL: resolveTaken = 1'b1;
         BR_CBZ:      resolveTaken = regZero;
         BR_CBNZ:     resolveTaken = ~regZero;
         BR_BCOND:    resolveTaken = condTaken;
         default:     resolveTaken = 1'b0;
      endcase
   end

   // ---------------- next state and outputs ----------------
   always_comb begin
      nextState  = state;
      uncondBr   = 1'b0;
      brTaken    = 1'b0;
      condAddr19 = '0;
      brAddr26   = '0;
      link       = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      unique case (state)
         IDLE: begin
            if (capture)
               nextState = RESOLVE;
         end
         RESOLVE: begin
            stall      = 1'b1;
            uncondBr   = (capClass == BR_B) || (capClass == BR_BL);
            condAddr19 = capAddr19;
            brAddr26   = capAddr26;
            brTaken    = resolveTaken;
            link       = (capClass == BR_BL);
            nextState  = resolveTaken ? FLUSH : IDLE;
         end
         FLUSH: begin
            flush     = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule
